// File: rtl/main_ctrl_pkg.sv
// Shared codes for the main-control mode FSM: command bytes, mode/state encoding, fault causes.
package main_ctrl_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h00;
    localparam logic [7:0] CMD_CON  = 8'h01;
    localparam logic [7:0] CMD_DOWN = 8'h02;

    // State encoding doubles as the externally visible mode register value.
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_DOWN  = 3'b100;
    localparam logic [2:0] ST_INI   = 3'b111;
    localparam logic [2:0] ST_RUN   = 3'b001;
    localparam logic [2:0] ST_CON   = 3'b010;
    localparam logic [2:0] ST_FAULT = 3'b110;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_INI_FAIL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

    function automatic logic cmd_legal(input logic [7:0] b);
        return (b == CMD_RUN) || (b == CMD_CON) || (b == CMD_DOWN);
    endfunction

endpackage

// File: rtl/main_ctrl_mc_cmd_qual.sv
// Mode-byte qualifier: a legal byte must hold CMD_STABLE cycles (current cycle included)
// before its run/con/down level asserts; illegal bytes give a one-cycle registered error pulse.
module cmd_qual
    import main_ctrl_pkg::*;
#(
    parameter int unsigned CMD_STABLE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mode_byte,
    output logic       q_run,
    output logic       q_con,
    output logic       q_down,
    output logic       cmd_err
);

    localparam int unsigned CW = $clog2(CMD_STABLE + 1);

    logic [7:0]    prev_byte;
    logic          prev_vld;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] run_len;
    logic          same;
    logic          legal;
    logic          qualified;

    always_comb begin
        same  = prev_vld && (mode_byte == prev_byte);
        legal = cmd_legal(mode_byte);
        // run_len saturates at CMD_STABLE so the level holds while the byte is unchanged
        if (!same)
            run_len = CW'(1);
        else if (run_cnt == CW'(CMD_STABLE))
            run_len = run_cnt;
        else
            run_len = run_cnt + CW'(1);
        qualified = legal && (run_len == CW'(CMD_STABLE));
        q_run  = qualified && (mode_byte == CMD_RUN);
        q_con  = qualified && (mode_byte == CMD_CON);
        q_down = qualified && (mode_byte == CMD_DOWN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_vld  <= 1'b0;
            prev_byte <= '0;
            run_cnt   <= '0;
            cmd_err   <= 1'b0;
        end else begin
            prev_vld  <= 1'b1;
            prev_byte <= mode_byte;
            run_cnt   <= run_len;
            cmd_err   <= !legal && !same;
        end
    end

endmodule

// File: rtl/main_ctrl_mc.sv
// Board main-control mode FSM: qualified mode commands, init sequencing with timeout and
// bounded retry, latched fault with cause code, and per-channel TX enable gating.
module main_ctrl_mc
    import main_ctrl_pkg::*;
#(
    parameter int unsigned CH_NUM         = 4,
    parameter int unsigned TD_MODE_CHANGE = 100,
    parameter int unsigned INI_TIMEOUT    = 50000,
    parameter int unsigned CMD_STABLE     = 3,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        im_mode_byte,
    input  logic              i_rst_req,
    input  logic [CH_NUM-1:0] im_ch_en,
    input  logic              i_ini_done,
    input  logic              i_ini_fail,
    output logic [2:0]        om_mode_reg,
    output logic              o_ini_start,
    output logic [CH_NUM-1:0] om_tb_txen,
    output logic              o_mb_txen,
    output logic              o_down_en,
    output logic              o_fault,
    output logic [1:0]        om_fault_code,
    output logic [2:0]        om_retry_cnt,
    output logic              o_cmd_err
);

    localparam int unsigned TW = $clog2(INI_TIMEOUT + 1);
    localparam int unsigned DW = $clog2(TD_MODE_CHANGE + 1);

    logic          q_run, q_con, q_down;
    logic [2:0]    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [DW-1:0] dly_cnt, dly_nxt;
    logic          dly_act, dly_act_nxt;
    logic [2:0]    retry, retry_nxt;
    logic [1:0]    code, code_nxt;
    logic          start_nxt;

    cmd_qual #(.CMD_STABLE(CMD_STABLE)) u_cmd_qual (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_byte(im_mode_byte),
        .q_run    (q_run),
        .q_con    (q_con),
        .q_down   (q_down),
        .cmd_err  (o_cmd_err)
    );

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        dly_nxt     = dly_cnt;
        dly_act_nxt = dly_act;
        retry_nxt   = retry;
        code_nxt    = code;
        start_nxt   = 1'b0;
        case (state)
            ST_IDLE: if (q_down) state_nxt = ST_DOWN;
            ST_DOWN: begin
                if (q_run || i_rst_req) begin
                    state_nxt   = ST_INI;
                    retry_nxt   = '0;
                    timer_nxt   = '0;
                    dly_act_nxt = 1'b0;
                    dly_nxt     = '0;
                    start_nxt   = 1'b1;
                end
            end
            ST_INI: begin
                // Abort beats everything; once the done delay runs, fail/timeout are ignored.
                if (q_down) begin
                    state_nxt   = ST_DOWN;
                    retry_nxt   = '0;
                    timer_nxt   = '0;
                    dly_act_nxt = 1'b0;
                    dly_nxt     = '0;
                end else if (dly_act) begin
                    if (dly_cnt == DW'(TD_MODE_CHANGE - 1)) begin
                        state_nxt   = ST_RUN;
                        dly_act_nxt = 1'b0;
                        dly_nxt     = '0;
                    end else begin
                        dly_nxt = dly_cnt + DW'(1);
                    end
                end else if (i_ini_fail || (timer == TW'(INI_TIMEOUT))) begin
                    if (retry < 3'(MAX_RETRY)) begin
                        retry_nxt = retry + 3'd1;
                        timer_nxt = '0;
                        start_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_FAULT;
                        code_nxt  = i_ini_fail ? FLT_INI_FAIL : FLT_TIMEOUT;
                    end
                end else if (i_ini_done) begin
                    dly_act_nxt = 1'b1;
                    dly_nxt     = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ST_RUN: begin
                if (q_down)     state_nxt = ST_DOWN;
                else if (q_con) state_nxt = ST_CON;
            end
            ST_CON: begin
                if (q_run)       state_nxt = ST_RUN;
                else if (q_down) state_nxt = ST_DOWN;
            end
            ST_FAULT: begin
                if (q_down) begin
                    state_nxt = ST_DOWN;
                    code_nxt  = FLT_NONE;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            dly_cnt     <= '0;
            dly_act     <= 1'b0;
            retry       <= '0;
            code        <= FLT_NONE;
            o_ini_start <= 1'b0;
            om_tb_txen  <= '0;
            o_down_en   <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            dly_cnt     <= dly_nxt;
            dly_act     <= dly_act_nxt;
            retry       <= retry_nxt;
            code        <= code_nxt;
            o_ini_start <= start_nxt;
            om_tb_txen  <= ((state_nxt == ST_RUN) || (state_nxt == ST_CON)) ? im_ch_en : '0;
            o_down_en   <= (state_nxt == ST_DOWN);
            o_fault     <= (state_nxt == ST_FAULT);
        end
    end

    assign om_mode_reg   = state;
    assign om_fault_code = code;
    assign om_retry_cnt  = retry;
    assign o_mb_txen     = 1'b1;

endmodule
